wb_stage: RTL and testbench



---
 rtl/core_pkg.sv | 30 +++
 rtl/wb_stage_if.sv | 53 +++++
 rtl/load_align.sv | 52 +++++
 rtl/wb_stage.sv | 133 +++++++++++++
 tb/tb_wb_stage.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared types and constants for the RV32I core pipeline.
//   result_sel_t : writeback source select (ALU result, load data, PC+4)
//   F3_*         : funct3 encodings of the RV32I load instructions
//   wb_state_t   : writeback stage FSM states
// -----------------------------------------------------------------------------
package core_pkg;

  localparam int XLEN_DEFAULT = 32;

  // Encoding 2'd3 is unused and decodes as ALU wherever it is compared.
  typedef enum logic [1:0] {
    ALU  = 2'd0,
    LOAD = 2'd1,
    PC4  = 2'd2
  } result_sel_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_t;

endpackage

// File: rtl/wb_stage_if.sv
// -----------------------------------------------------------------------------
// wb_stage_if
// MEM -> WB retirement channel (valid/ready handshake plus payload).
//   master : MEM stage; drives in_valid and the payload, observes in_ready
//   slave  : WB stage; observes in_valid and the payload, drives in_ready
// Payload:
//   in_wb_en       instruction writes rd
//   in_rd          destination register
//   in_result_sel  0 ALU, 1 LOAD, 2 PC+4 (3 behaves as ALU)
//   in_alu_result  ALU result
//   in_pc          instruction PC
//   in_funct3      load type
//   in_addr_lo     byte offset of the load address
// -----------------------------------------------------------------------------
interface wb_stage_if #(
  parameter int XLEN = 32
);

  logic            in_valid;
  logic            in_ready;
  logic            in_wb_en;
  logic [4:0]      in_rd;
  logic [1:0]      in_result_sel;
  logic [XLEN-1:0] in_alu_result;
  logic [XLEN-1:0] in_pc;
  logic [2:0]      in_funct3;
  logic [1:0]      in_addr_lo;

  modport master (
    output in_valid,
    output in_wb_en,
    output in_rd,
    output in_result_sel,
    output in_alu_result,
    output in_pc,
    output in_funct3,
    output in_addr_lo,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_wb_en,
    input  in_rd,
    input  in_result_sel,
    input  in_alu_result,
    input  in_pc,
    input  in_funct3,
    input  in_addr_lo,
    output in_ready
  );

endinterface

// File: rtl/load_align.sv
// -----------------------------------------------------------------------------
// load_align
// Purely combinational load formatter: picks the byte/halfword lane out of an
// aligned read word and sign- or zero-extends it according to funct3.
//   funct3  : load type (LB, LH, LW, LBU, LHU; 3/6/7 behave as LW)
//   addr_lo : byte offset of the load address
//   rdata   : naturally aligned read word from data memory
//   value   : formatted XLEN-bit load result
// -----------------------------------------------------------------------------
module load_align
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] value
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // NOTE: every signal assigned in always_comb gets a default at the top so
  // that no path through the block leaves it unassigned and infers a latch.
  always_comb begin
    byte_lane = rdata[7:0];
    unique case (addr_lo)
      2'd0: byte_lane = rdata[7:0];
      2'd1: byte_lane = rdata[15:8];
      2'd2: byte_lane = rdata[23:16];
      2'd3: byte_lane = rdata[31:24];
      default: byte_lane = rdata[7:0];
    endcase
  end

  // Halfword lane depends only on addr_lo[1]; a misaligned offset bit 0 is
  // deliberately ignored rather than trapping here.
  assign half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    value = rdata;
    case (funct3)
      F3_LB:   value = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      F3_LH:   value = {{(XLEN-16){half_lane[15]}}, half_lane};
      F3_LBU:  value = {{(XLEN-8){1'b0}}, byte_lane};
      F3_LHU:  value = {{(XLEN-16){1'b0}}, half_lane};
      default: value = rdata;  // LW and the unused encodings
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
// Writeback stage of the 5-stage RV32I core; write-side master of the register
// file. Retires one instruction per cycle from the MEM stage, stalls on loads
// until the data-memory response arrives, formats load data and drives the
// register-file write port (the register file commits on the falling edge).
// Ports:
//   clk, rst_n    core clock, asynchronous active-low reset
//   bus           MEM -> WB retirement channel (slave side)
//   mem_rvalid    data-memory read response valid (one cycle per response)
//   mem_rdata     naturally aligned read word
//   WB            register-file write enable, one-cycle pulse
//   rd_address    register-file write address
//   write_data    register-file write data
//   load_pending  a load is waiting for its memory response
//   pending_rd    rd of the waiting load, 0 when none is waiting
//   rsp_err       sticky: a memory response arrived with no load waiting
// -----------------------------------------------------------------------------
module wb_stage
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  wb_stage_if.slave       bus,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            WB,
  output logic [4:0]      rd_address,
  output logic [XLEN-1:0] write_data,
  output logic            load_pending,
  output logic [4:0]      pending_rd,
  output logic            rsp_err
);

  wb_state_t       state;

  // Load context captured at acceptance; used when the response returns.
  logic            cap_wb_en;
  logic [4:0]      cap_rd;
  logic [2:0]      cap_funct3;
  logic [1:0]      cap_addr_lo;

  logic            is_load;
  logic            direct_wr;
  logic            load_wr;
  logic [XLEN-1:0] direct_value;
  logic [XLEN-1:0] load_value;

  load_align #(
    .XLEN (XLEN)
  ) u_load_align (
    .funct3  (cap_funct3),
    .addr_lo (cap_addr_lo),
    .rdata   (mem_rdata),
    .value   (load_value)
  );

  assign is_load = (bus.in_result_sel == LOAD);

  // Non-load result mux; PC+4 wraps modulo 2^XLEN by plain truncation.
  assign direct_value = (bus.in_result_sel == PC4) ? bus.in_pc + XLEN'(4)
                                                   : bus.in_alu_result;

  // x0 is hard-wired to zero, so a write to it is suppressed here.
  assign direct_wr = bus.in_wb_en && (bus.in_rd != 5'd0);
  assign load_wr   = cap_wb_en && (cap_rd != 5'd0);

  // Handshake and hazard status are decoded from state alone so that
  // in_ready never depends combinationally on in_valid.
  assign bus.in_ready = (state == IDLE);
  assign load_pending = (state == WAIT_MEM);
  assign pending_rd   = load_pending ? cap_rd : 5'd0;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      WB          <= 1'b0;
      rd_address  <= 5'd0;
      write_data  <= '0;
      rsp_err     <= 1'b0;
      cap_wb_en   <= 1'b0;
      cap_rd      <= 5'd0;
      cap_funct3  <= F3_LW;
      cap_addr_lo <= 2'd0;
    end else begin
      // WB is a one-cycle pulse; address and data hold unless a write occurs.
      WB <= 1'b0;

      case (state)
        IDLE: begin
          // A response with no load outstanding is dropped but remembered.
          if (mem_rvalid) begin
            rsp_err <= 1'b1;
          end

          if (bus.in_valid) begin
            if (is_load) begin
              cap_wb_en   <= bus.in_wb_en;
              cap_rd      <= bus.in_rd;
              cap_funct3  <= bus.in_funct3;
              cap_addr_lo <= bus.in_addr_lo;
              state       <= WAIT_MEM;
            end else if (direct_wr) begin
              WB         <= 1'b1;
              rd_address <= bus.in_rd;
              write_data <= direct_value;
            end
          end
        end

        WAIT_MEM: begin
          // A load with no architectural write still blocks until its
          // response so the memory interface stays in step.
          if (mem_rvalid) begin
            if (load_wr) begin
              WB         <= 1'b1;
              rd_address <= cap_rd;
              write_data <= load_value;
            end
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage
// Directed, self-checking bench for wb_stage. Inputs change on the falling
// edge; outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        WB;
  logic [4:0]  rd_address;
  logic [31:0] write_data;
  logic        load_pending;
  logic [4:0]  pending_rd;
  logic        rsp_err;

  int n_cmp = 0;
  int n_mis = 0;

  wb_stage_if #(.XLEN(32)) bus ();

  wb_stage #(
    .XLEN (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .WB           (WB),
    .rd_address   (rd_address),
    .write_data   (write_data),
    .load_pending (load_pending),
    .pending_rd   (pending_rd),
    .rsp_err      (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wb_en, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [31:0] alu,
                       input logic [31:0] pc, input logic [2:0] f3,
                       input logic [1:0] alo);
    @(negedge clk);
    bus.in_valid      = 1'b1;
    bus.in_wb_en      = wb_en;
    bus.in_rd         = rd;
    bus.in_result_sel = sel;
    bus.in_alu_result = alu;
    bus.in_pc         = pc;
    bus.in_funct3     = f3;
    bus.in_addr_lo    = alo;
  endtask

  task automatic go_idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Issue a load, answer it 'delay' cycles after acceptance, and check the
  // stall status, the write pulse and the register-file outputs.
  task automatic do_load(input string tag, input logic [2:0] f3,
                         input logic [1:0] alo, input logic [4:0] rd,
                         input logic wb_en, input int delay,
                         input logic [31:0] rdata, input logic exp_wb,
                         input logic [4:0] exp_rd, input logic [31:0] exp_data);
    issue(wb_en, rd, 2'd1, 32'h0, 32'h0, f3, alo);
    step();
    check({tag, " acc WB"}, 32'(WB), 32'd0);
    check({tag, " acc pend"}, 32'(load_pending), 32'd1);
    check({tag, " acc prd"}, 32'(pending_rd), 32'(rd));
    check({tag, " acc rdy"}, 32'(bus.in_ready), 32'd0);
    for (int i = 1; i < delay; i++) begin
      go_idle();
      step();
      check({tag, " wait WB"}, 32'(WB), 32'd0);
      check({tag, " wait pend"}, 32'(load_pending), 32'd1);
      check({tag, " wait rdy"}, 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    mem_rvalid   = 1'b1;
    mem_rdata    = rdata;
    step();
    check({tag, " rsp WB"}, 32'(WB), 32'(exp_wb));
    check({tag, " rsp rd"}, 32'(rd_address), 32'(exp_rd));
    check({tag, " rsp data"}, write_data, exp_data);
    check({tag, " rsp pend"}, 32'(load_pending), 32'd0);
    check({tag, " rsp prd"}, 32'(pending_rd), 32'd0);
    check({tag, " rsp rdy"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    mem_rvalid = 1'b0;
    step();
    check({tag, " post WB"}, 32'(WB), 32'd0);
    check({tag, " post err"}, 32'(rsp_err), 32'd0);
  endtask

  initial begin
    rst_n             = 1'b0;
    mem_rvalid        = 1'b0;
    mem_rdata         = 32'h0;
    bus.in_valid      = 1'b0;
    bus.in_wb_en      = 1'b0;
    bus.in_rd         = 5'd0;
    bus.in_result_sel = 2'd0;
    bus.in_alu_result = 32'h0;
    bus.in_pc         = 32'h0;
    bus.in_funct3     = 3'd0;
    bus.in_addr_lo    = 2'd0;

    // Reset state
    #1;
    check("rst WB", 32'(WB), 32'd0);
    check("rst rd", 32'(rd_address), 32'd0);
    check("rst data", write_data, 32'h0);
    check("rst err", 32'(rsp_err), 32'd0);
    check("rst prd", 32'(pending_rd), 32'd0);
    check("rst rdy", 32'(bus.in_ready), 32'd1);
    check("rst pend", 32'(load_pending), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back ALU ops
    issue(1'b1, 5'd5, 2'd0, 32'h1234_5678, 32'h0, 3'd0, 2'd0);
    step();
    check("alu1 WB", 32'(WB), 32'd1);
    check("alu1 rd", 32'(rd_address), 32'd5);
    check("alu1 data", write_data, 32'h1234_5678);
    check("alu1 rdy", 32'(bus.in_ready), 32'd1);
    issue(1'b1, 5'd6, 2'd0, 32'hDEAD_BEEF, 32'h0, 3'd0, 2'd0);
    step();
    check("alu2 WB", 32'(WB), 32'd1);
    check("alu2 rd", 32'(rd_address), 32'd6);
    check("alu2 data", write_data, 32'hDEAD_BEEF);
    check("alu2 rdy", 32'(bus.in_ready), 32'd1);
    go_idle();
    step();
    check("idle WB", 32'(WB), 32'd0);
    check("idle rd hold", 32'(rd_address), 32'd6);
    check("idle data hold", write_data, 32'hDEAD_BEEF);

    // Load formatting, rdata = 0x8070_F1A2, minimum latency
    do_load("lb1",  3'd0, 2'd1, 5'd10, 1'b1, 1, 32'h8070_F1A2, 1'b1, 5'd10, 32'hFFFF_FFF1);
    do_load("lbu1", 3'd4, 2'd1, 5'd11, 1'b1, 1, 32'h8070_F1A2, 1'b1, 5'd11, 32'h0000_00F1);
    do_load("lh2",  3'd1, 2'd2, 5'd12, 1'b1, 1, 32'h8070_F1A2, 1'b1, 5'd12, 32'hFFFF_8070);
    do_load("lhu3", 3'd5, 2'd3, 5'd13, 1'b1, 1, 32'h8070_F1A2, 1'b1, 5'd13, 32'h0000_8070);
    do_load("lw",   3'd2, 2'd3, 5'd14, 1'b1, 1, 32'h8070_F1A2, 1'b1, 5'd14, 32'h8070_F1A2);
    do_load("lb3",  3'd0, 2'd3, 5'd15, 1'b1, 1, 32'h8070_F1A2, 1'b1, 5'd15, 32'hFFFF_FF80);
    do_load("lb0",  3'd0, 2'd0, 5'd16, 1'b1, 1, 32'h8070_F1A2, 1'b1, 5'd16, 32'hFFFF_FFA2);
    do_load("lbu2", 3'd4, 2'd2, 5'd17, 1'b1, 1, 32'h8070_F1A2, 1'b1, 5'd17, 32'h0000_0070);
    do_load("lh0",  3'd1, 2'd1, 5'd18, 1'b1, 1, 32'h8070_F1A2, 1'b1, 5'd18, 32'hFFFF_F1A2);
    do_load("f3_6", 3'd6, 2'd1, 5'd19, 1'b1, 1, 32'h8070_F1A2, 1'b1, 5'd19, 32'h8070_F1A2);

    // Load with a 3-cycle memory delay
    do_load("lw_d3", 3'd2, 2'd0, 5'd9, 1'b1, 3, 32'h0BAD_F00D, 1'b1, 5'd9, 32'h0BAD_F00D);

    // rd = 0 ALU op: no write, outputs hold
    issue(1'b1, 5'd0, 2'd0, 32'h0000_0055, 32'h0, 3'd0, 2'd0);
    step();
    check("x0 WB", 32'(WB), 32'd0);
    check("x0 rd hold", 32'(rd_address), 32'd9);
    check("x0 data hold", write_data, 32'h0BAD_F00D);
    check("x0 rdy", 32'(bus.in_ready), 32'd1);
    go_idle();

    // Load with wb_en = 0 still blocks for its response, never writes
    do_load("nowb", 3'd2, 2'd0, 5'd7, 1'b0, 2, 32'hCAFE_0001, 1'b0, 5'd9, 32'h0BAD_F00D);

    // PC+4, including wraparound
    issue(1'b1, 5'd3, 2'd2, 32'h1111_1111, 32'hFFFF_FFFC, 3'd0, 2'd0);
    step();
    check("pc4 wrap WB", 32'(WB), 32'd1);
    check("pc4 wrap rd", 32'(rd_address), 32'd3);
    check("pc4 wrap data", write_data, 32'h0000_0000);
    issue(1'b1, 5'd4, 2'd2, 32'h1111_1111, 32'h0000_0100, 3'd0, 2'd0);
    step();
    check("pc4 data", write_data, 32'h0000_0104);
    // result_sel = 3 behaves as ALU
    issue(1'b1, 5'd8, 2'd3, 32'h2222_3333, 32'h0000_0200, 3'd0, 2'd0);
    step();
    check("sel3 WB", 32'(WB), 32'd1);
    check("sel3 rd", 32'(rd_address), 32'd8);
    check("sel3 data", write_data, 32'h2222_3333);

    // Reset in the middle of WAIT_MEM, then a late response
    issue(1'b1, 5'd12, 2'd1, 32'h0, 32'h0, 3'd2, 2'd0);
    step();
    check("mid pend", 32'(load_pending), 32'd1);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid rst WB", 32'(WB), 32'd0);
    check("mid rst rd", 32'(rd_address), 32'd0);
    check("mid rst data", write_data, 32'h0);
    check("mid rst pend", 32'(load_pending), 32'd0);
    check("mid rst prd", 32'(pending_rd), 32'd0);
    check("mid rst rdy", 32'(bus.in_ready), 32'd1);
    check("mid rst err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1111_1111;
    step();
    check("late err", 32'(rsp_err), 32'd1);
    check("late WB", 32'(WB), 32'd0);
    check("late rd", 32'(rd_address), 32'd0);
    check("late data", write_data, 32'h0);
    check("late rdy", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    mem_rvalid = 1'b0;
    step();
    step();
    check("sticky err", 32'(rsp_err), 32'd1);
    issue(1'b1, 5'd21, 2'd0, 32'h0000_ABCD, 32'h0, 3'd0, 2'd0);
    step();
    check("after WB", 32'(WB), 32'd1);
    check("after data", write_data, 32'h0000_ABCD);
    check("after err", 32'(rsp_err), 32'd1);
    go_idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
